// File: rtl/input_pkg.sv
// Shared types and timing defaults for the push-button input path.
// Every key_repeater instance pulls its defaults from here.
package input_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } key_state_t;

    localparam int KEY_DELAY_CYCLES  = 16;
    localparam int KEY_REPEAT_CYCLES = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_repeater.sv
// Turns a debounced button level into press / release / auto-repeat strobes.
// All outputs are registered; the hold counter is cleared on every transition.
module key_repeater
    import input_pkg::*;
#(
    parameter int DELAY_CYCLES  = KEY_DELAY_CYCLES,
    parameter int REPEAT_CYCLES = KEY_REPEAT_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic key_event,
    output logic held
);

    localparam int CNT_BITS =
        $clog2(max_int(DELAY_CYCLES, REPEAT_CYCLES) + 1);

    localparam logic [CNT_BITS-1:0] DLY_LAST = CNT_BITS'(DELAY_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] REP_LAST = CNT_BITS'(REPEAT_CYCLES - 1);

    if (DELAY_CYCLES < 2) begin : g_bad_delay
        $error("key_repeater: DELAY_CYCLES must be >= 2");
    end

    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("key_repeater: REPEAT_CYCLES must be >= 1");
    end

    key_state_t          state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    logic press_q, press_d;
    logic release_q, release_d;
    logic repeat_q, repeat_d;
    logic key_q, key_d;
    logic held_q, held_d;

    logic dly_exp;
    logic rep_exp;

    assign dly_exp = (cnt_q == DLY_LAST);
    assign rep_exp = (cnt_q == REP_LAST);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            key_q     <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            key_q     <= key_d;
            held_q    <= held_d;
        end
    end

    // Release always wins over a counter expiry on the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (!in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (dly_exp) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (rep_exp) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        press_d   = (state_q == IDLE) && in;
        release_d = ((state_q == HOLD) || (state_q == REPEAT)) && !in;
        repeat_d  = in && (((state_q == HOLD) && dly_exp) ||
                           ((state_q == REPEAT) && rep_exp));
        key_d     = press_d | repeat_d;
        held_d    = (state_d == REPEAT);
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign key_event     = key_q;
    assign held          = held_q;

endmodule
